// File: rtl/seq_detect_ctrl.sv
// Sequencing controller for a serial sequence detector: loads a word, clears the
// detector, shifts the word out MSB first and returns the number of z hits.
module seq_detect_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned ZLAT  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             x_out,
    output logic             det_clr,
    input  logic             z_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int unsigned BCW = $clog2(WIDTH + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [BCW-1:0]   bit_q, bit_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             x_out_q, x_out_d;
    logic             det_clr_q, det_clr_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             z_take;

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        bit_d       = bit_q;
        count_d     = count_q;
        x_out_d     = 1'b0;
        det_clr_d   = 1'b0;
        out_valid_d = out_valid_q;
        out_count_d = out_count_q;
        z_take      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sh_d      = in_data;
                    count_d   = '0;
                    bit_d     = '0;
                    det_clr_d = 1'b1;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                x_out_d = sh_q[WIDTH-1];
                sh_d    = sh_q << 1;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                // A Moore detector's z during bit 0 still reflects the clear, so skip it.
                z_take = (ZLAT == 0) || (bit_q != '0);
                if (bit_q == LAST_BIT) begin
                    state_d = (ZLAT == 1) ? S_DRAIN : S_DONE;
                end else begin
                    x_out_d = sh_q[WIDTH-1];
                    sh_d    = sh_q << 1;
                    bit_d   = bit_q + BCW'(1);
                end
            end
            S_DRAIN: begin
                z_take  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (z_take && z_in && (count_q != CNT_MAX))
            count_d = count_q + CNT_W'(1);

        // Publish the final count (including the last sampled z) on entry to DONE.
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            out_valid_d = 1'b1;
            out_count_d = count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sh_q        <= '0;
            bit_q       <= '0;
            count_q     <= '0;
            x_out_q     <= 1'b0;
            det_clr_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            bit_q       <= bit_d;
            count_q     <= count_d;
            x_out_q     <= x_out_d;
            det_clr_q   <= det_clr_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign x_out     = x_out_q;
    assign det_clr   = det_clr_q;
    assign out_valid = out_valid_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: three instances (Mealy, Moore, 2-bit saturating count)
// driven by detector models and checked every cycle against a word-level model.
module tb_seq_detect_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       iv [3];
    logic [7:0] id [3];
    logic       ordy [3];
    logic       ir_o [3], x_o [3], clr_o [3], ov_o [3], busy_o [3];
    logic [3:0] cnt_o [3];
    logic [1:0] cnt2;
    logic       z0, z1, z2;

    seq_detect_ctrl #(.WIDTH(8), .CNT_W(4), .ZLAT(0)) u_mealy (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir_o[0]), .in_data(id[0]),
        .x_out(x_o[0]), .det_clr(clr_o[0]), .z_in(z0), .out_valid(ov_o[0]),
        .out_ready(ordy[0]), .out_count(cnt_o[0]), .busy(busy_o[0]));

    seq_detect_ctrl #(.WIDTH(8), .CNT_W(4), .ZLAT(1)) u_moore (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir_o[1]), .in_data(id[1]),
        .x_out(x_o[1]), .det_clr(clr_o[1]), .z_in(z1), .out_valid(ov_o[1]),
        .out_ready(ordy[1]), .out_count(cnt_o[1]), .busy(busy_o[1]));

    seq_detect_ctrl #(.WIDTH(8), .CNT_W(2), .ZLAT(0)) u_sat (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir_o[2]), .in_data(id[2]),
        .x_out(x_o[2]), .det_clr(clr_o[2]), .z_in(z2), .out_valid(ov_o[2]),
        .out_ready(ordy[2]), .out_count(cnt2), .busy(busy_o[2]));

    assign cnt_o[2] = {2'b00, cnt2};

    // Detector models for overlapping "101": h holds the two previous bits.
    logic [1:0] h0, h1;
    logic       zm1;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            h0 <= 2'b00; h1 <= 2'b00; zm1 <= 1'b0;
        end else begin
            h0  <= clr_o[0] ? 2'b00 : {h0[0], x_o[0]};
            h1  <= clr_o[1] ? 2'b00 : {h1[0], x_o[1]};
            zm1 <= clr_o[1] ? 1'b0 : ((h1 == 2'b10) && x_o[1]);
        end
    end
    assign z0 = (h0 == 2'b10) && x_o[0];
    assign z1 = zm1;
    assign z2 = 1'b1;

    function automatic int cnt101(input logic [7:0] w);
        int n = 0;
        for (int k = 2; k < 8; k++)
            if (w[9-k] && !w[8-k] && w[7-k]) n++;
        return n;
    endfunction

    function automatic int exp_count(input int i, input logic [7:0] w);
        int raw = (i == 2) ? W : cnt101(w);
        int mx  = (i == 2) ? 3 : 15;
        return (raw > mx) ? mx : raw;
    endfunction

    function automatic int zl(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    // Word-level model: ph=-1 idle, 0 load, 1..W bits, W+1 drain (Moore), last = done.
    int         ph [3];
    logic [7:0] word [3];
    int         last_cnt [3];
    int         cyc [3];
    int         lit_cnt [3], lit_lat [3];

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                ph[i] <= -1; last_cnt[i] <= 0; cyc[i] <= 0;
            end else if (ph[i] == -1) begin
                if (iv[i]) begin
                    ph[i] <= 0; word[i] <= id[i]; cyc[i] <= 0;
                end
            end else begin
                cyc[i] <= cyc[i] + 1;
                if (ph[i] == W + 1 + zl(i)) begin
                    if (ordy[i]) ph[i] <= -1;
                end else begin
                    ph[i] <= ph[i] + 1;
                    if (ph[i] + 1 == W + 1 + zl(i)) last_cnt[i] <= exp_count(i, word[i]);
                end
            end
        end
    end

    int   vecs = 0;
    int   errs = 0;
    logic ov_prev [3];

    task automatic chk(input string n, input int i, input logic [7:0] a, input logic [7:0] e);
        vecs++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s inst%0d t=%0t got=%0d want=%0d", n, i, $time, a, e);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic ex;
            ex = (ph[i] >= 1 && ph[i] <= W) ? word[i][W-ph[i]] : 1'b0;
            chk("in_ready", i, 8'(ir_o[i]), 8'(ph[i] == -1));
            chk("busy", i, 8'(busy_o[i]), 8'(ph[i] != -1));
            chk("det_clr", i, 8'(clr_o[i]), 8'(ph[i] == 0));
            chk("x_out", i, 8'(x_o[i]), 8'(ex));
            chk("out_valid", i, 8'(ov_o[i]), 8'(ph[i] == W + 1 + zl(i)));
            chk("out_count", i, 8'(cnt_o[i]), 8'(last_cnt[i]));
            if (rst) begin
                chk("rst_x", i, 8'(x_o[i]), 8'd0);
                chk("rst_busy", i, 8'(busy_o[i]), 8'd0);
                chk("rst_ov", i, 8'(ov_o[i]), 8'd0);
            end else if (ov_o[i] && !ov_prev[i]) begin
                chk("lit_count", i, 8'(cnt_o[i]), 8'(lit_cnt[i]));
                chk("lit_latency", i, 8'(cyc[i]), 8'(lit_lat[i]));
            end
            ov_prev[i] <= ov_o[i];
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Send one word, wait for the result, hold it `hold` cycles (pulsing in_valid), then take it.
    task automatic run(input int i, input logic [7:0] d, input int lc, input int ll, input int hold);
        lit_cnt[i] = lc; lit_lat[i] = ll;
        iv[i] = 1'b1; id[i] = d;
        tick(1);
        iv[i] = 1'b0; id[i] = ~d;
        tick(ll);
        for (int k = 0; k < hold; k++) begin
            iv[i] = (k % 2 == 0);
            tick(1);
        end
        iv[i] = 1'b0;
        ordy[i] = 1'b1;
        tick(1);
        ordy[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; id[i] = 8'h00; ordy[i] = 1'b0;
            lit_cnt[i] = 0; lit_lat[i] = 0; ov_prev[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        tick(1);

        run(0, 8'b1010_1010, 3, 9, 0);
        run(0, 8'hFF, 0, 9, 0);
        run(0, 8'h00, 0, 9, 0);
        run(0, 8'b1010_1010, 3, 9, 5);
        run(0, 8'h5A, 2, 9, 0);

        ordy[1] = 1'b1;
        tick(3);
        ordy[1] = 1'b0;
        run(1, 8'b1011_0101, 3, 10, 0);
        run(1, 8'h5A, 2, 10, 2);

        // Abort in SHIFT bit 4, then make sure the next word is unaffected.
        iv[0] = 1'b1; id[0] = 8'hFF;
        tick(1);
        iv[0] = 1'b0;
        tick(5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        run(0, 8'b1010_1010, 3, 9, 0);

        run(2, 8'hFF, 3, 9, 3);
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Sequencing controller for the serial sequence-detector FSM (single-bit input x, single-bit flag z).
- Accepts a parallel word over a valid/ready handshake and clears the detector before each word.
- Drives the word onto the detector's x input one bit per clock, MSB first.
- Counts z assertions over the word and returns the count over a second valid/ready handshake.

Parameters:
- WIDTH, 8: bits per word shifted into the detector.
- CNT_W, 4: width of the detection count; must satisfy 2^CNT_W-1 >= WIDTH.
- ZLAT, 0: detector output latency. 0 means Mealy (z valid in the same cycle as the bit on x). 1 means Moore (z valid one cycle later). Only 0 and 1 are legal.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  input word available.
- in_ready  out  1  controller can accept a word.
- in_data  in  WIDTH  word to shift into the detector.
- x_out  out  1  serial bit to detector x, registered.
- det_clr  out  1  synchronous clear to detector, registered.
- z_in  in  1  detector z flag.
- out_valid  out  1  count result available.
- out_ready  in  1  consumer accepts result.
- out_count  out  CNT_W  number of z assertions for the last word.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, shift register=0, bit counter=0, count=0.
  - x_out=0, det_clr=0, out_valid=0, out_count=0.
  - in_ready=1 once rst deasserts; busy=0.
- States: IDLE, LOAD, SHIFT, DRAIN, DONE. All outputs except in_ready and busy are registered.
- IDLE:
  - in_ready=1.
  - If in_valid=1 at the rising edge: capture in_data, clear count, go to LOAD.
  - Otherwise hold.
- LOAD (exactly 1 cycle):
  - det_clr=1, x_out=0, in_ready=0, z_in ignored.
  - Next state is SHIFT.
- SHIFT (exactly WIDTH cycles, k=0..WIDTH-1):
  - x_out=in_data[WIDTH-1-k].
  - When ZLAT=0: at each edge ending a SHIFT cycle, if z_in=1 then count+=1.
  - When ZLAT=1: z_in is sampled at the edges ending SHIFT cycles 1..WIDTH-1 and the single DRAIN cycle; the edge ending SHIFT cycle 0 is ignored.
  - After cycle WIDTH-1, go to DRAIN if ZLAT=1, else DONE.
- DRAIN (ZLAT cycles):
  - x_out=0; sample z_in as above.
  - Next state is DONE.
- DONE:
  - out_valid=1, out_count=count; both held stable until out_ready=1 at an edge.
  - On that edge: out_valid drops, go to IDLE.
  - in_ready=0 while in DONE; a new word cannot be accepted in the same edge as the result handshake.
- Latency: out_valid rises exactly 1+WIDTH+ZLAT cycles after the edge that accepted the word.
- Throughput: maximum one word per 3+WIDTH+ZLAT cycles.
- Counting: count saturates at 2^CNT_W-1 and never wraps.
- in_data changes after acceptance have no effect; the word is latched.
- in_valid=1 outside IDLE is ignored, not queued.
- z_in is ignored in IDLE, LOAD and DONE; spurious z there does not alter the count.
- out_ready=1 while out_valid=0 has no effect.
- Reset mid-operation (any state):
  - Immediate return to IDLE with reset values.
  - No partial result is emitted.
  - The detector is cleared by the next LOAD.
- det_clr is high only in LOAD; x_out is 0 in every state except SHIFT.

Test Plan:
1. Reset, then in_data=8'b1010_1010 with a bench model of an overlapping "101" Mealy detector (ZLAT=0) -> x_out sequence 1,0,1,0,1,0,1,0; out_valid exactly 9 cycles after acceptance; out_count=3.
2. in_data=8'hFF, then 8'h00, same model -> out_count=0 both times; det_clr pulses one cycle before each word's first bit; no carry-over between words.
3. out_ready held low 5 cycles in DONE -> out_valid and out_count=3 stable throughout; in_ready=0; in_valid pulses ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
4. ZLAT=1, Moore "101" model, in_data=8'b1011_0101 -> out_count=3; out_valid 10 cycles after acceptance; one DRAIN cycle with x_out=0.
5. rst asserted in SHIFT bit 4 -> x_out=0, busy=0, out_valid=0 immediately. Next word 8'b1010_1010 -> out_count=3, unaffected by the aborted word.
6. CNT_W=2 with a detector model forcing z_in=1 every cycle, in_data=8'hFF -> out_count saturates at 3; z_in=1 during IDLE/LOAD/DONE not counted.
